ram_stream_reader: RTL and testbench

- Drives the read port of the team's dual-port RAM (ram_dp_generic) and converts a burst request into a valid/ready word stream with full backpressure.
- A producer fills a frame/line buffer through the RAM write port; this block is the consumer end. It reads a contiguous, wrapping address range and streams it to downstream logic such as the pixel/LED shift-out path.
- Sustains 1 word/clock when out_ready is held high.

---
 rtl/ram_stream_reader_pkg.sv | 21 ++
 rtl/stream_fifo_small.sv | 53 +++++
 rtl/ram_stream_reader.sv | 127 ++++++++++++
 tb/tb_ram_stream_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader: FSM encoding,
// output FIFO geometry and the read-credit rule.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;

  // A new read may issue only if every word already owed to the FIFO still fits.
  function automatic logic has_credit(input logic [FIFO_PTR_W:0] fifo_count,
                                      input logic [1:0]          inflight);
    return ({1'b0, fifo_count} + {2'b00, inflight}) < 4'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/stream_fifo_small.sv
// Four-entry synchronous FIFO with a flush input; the head entry is visible
// combinationally so the stream interface can present it directly.
module stream_fifo_small
  import ram_stream_reader_pkg::*;
#(
  parameter int Width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [Width-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [Width-1:0]      head_data_o,
  output logic [FIFO_PTR_W:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [Width-1:0]      mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_PTR_W:0]   count_q;
  logic                  do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (FIFO_PTR_W+1)'(FIFO_DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;

  // Pointers are exactly FIFO_PTR_W bits, so they wrap at the depth for free.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a wrapping address range from a dual-port RAM read port and streams
// the words out over valid/ready with full backpressure.
//
// Stream handshake: a word transfers on a cycle where out_valid and out_ready
// are both high; once out_valid rises, out_valid/out_data/out_last hold until
// that transfer (only abort or reset may withdraw them).
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int DataDepth  = 1024,
  parameter int AddrWidth  = 10,
  parameter int CountWidth = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AddrWidth-1:0]  start_addr,
  input  logic [CountWidth-1:0] start_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_read_en,
  output logic [AddrWidth-1:0]  ram_read_addr,
  input  logic [DataWidth-1:0]  ram_read_data,
  output logic [DataWidth-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            dbg_state
);

  localparam int EntryW = DataWidth + 1;
  localparam logic [AddrWidth-1:0] ADDR_LAST = AddrWidth'(DataDepth - 1);

  state_t                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [CountWidth-1:0] remaining_q, remaining_d;
  logic                  bus_valid_q, bus_last_q;

  logic                  issue, issue_last, abort_now, pop, push;
  logic [EntryW-1:0]     fifo_head;
  logic [FIFO_PTR_W:0]   fifo_count;
  logic                  fifo_empty, fifo_full;

  // bus_valid_q marks a read whose data is on ram_read_data this cycle.
  assign abort_now  = abort && (state_q == S_READ || state_q == S_DRAIN);
  assign issue      = (state_q == S_READ) && has_credit(fifo_count, {1'b0, bus_valid_q});
  assign issue_last = issue && (remaining_q == CountWidth'(1));
  assign push       = bus_valid_q & ~fifo_full;

  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_head[DataWidth-1:0];
  assign out_last   = ~fifo_empty & fifo_head[DataWidth];
  assign pop        = out_valid & out_ready;
  assign dbg_state  = state_q;

  stream_fifo_small #(
    .Width(EntryW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (abort_now),
    .push_i      (push),
    .push_data_i ({bus_last_q, ram_read_data}),
    .pop_i       (pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    busy          = 1'b0;
    done          = 1'b0;
    ram_read_en   = 1'b0;
    ram_read_addr = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = start_count;
          state_d     = (start_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        busy        = 1'b1;
        ram_read_en = issue;
        if (issue) begin
          addr_d      = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && out_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_now) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      bus_valid_q <= 1'b0;
      bus_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      bus_valid_q <= issue & ~abort_now;
      bus_last_q  <= issue_last;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model, directed and random bursts,
// expected-word queue checked by an independent stream monitor.
module tb_ram_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int CW    = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] start_count = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, ram_read_en, out_valid, out_last;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data = '0;
  logic [DW-1:0] out_data;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [DEPTH];
  logic [DW:0]   exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            exp_done = 0;
  int            done_seen = 0;
  int            cyc = 0;
  int            ready_mode = 0;
  logic          stall_prev = 1'b0;
  logic [DW:0]   stall_word = '0;

  ram_stream_reader #(
    .DataWidth (DW),
    .DataDepth (DEPTH),
    .AddrWidth (AW),
    .CountWidth(CW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .start_count  (start_count),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .ram_read_en  (ram_read_en),
    .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .dbg_state    (dbg_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

  always @(posedge clk) if (ram_read_en) ram_read_data <= mem[ram_read_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready pattern generator
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 1'b0;
      continue;
    end
    if (stall_prev) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, stall_word});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none (t=%0t)", {out_last, out_data}, $time);
      end else begin
        check("word", {out_last, out_data}, exp_q.pop_front());
      end
    end
    if (done) done_seen++;
    stall_prev = out_valid && !out_ready && !abort;
    stall_word = {out_last, out_data};
  end

  // driver tasks
  task automatic start_burst(input int a, input int n);
    @(posedge clk);
    #1;
    start       = 1'b1;
    start_addr  = AW'(a);
    start_count = CW'(n);
    exp_done++;
    for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), mem[(a + k) % DEPTH]});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || done || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d queued words expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
    check({name, "_done_count"}, done_seen, exp_done);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ctrl"}, {busy, done, ram_read_en, out_valid, out_last}, 5'b0);
    check({name, "_addr"}, ram_read_addr, 0);
    check({name, "_data"}, out_data, 0);
    check({name, "_state"}, dbg_state, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // latency and throughput of a plain burst
    ready_mode = 0;
    start_burst(16, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("t1_rd_en", ram_read_en, (c <= 4));
      if (c <= 4) check("t1_rd_addr", ram_read_addr, 16 + c - 1);
      check("t1_valid", out_valid, (c >= 3 && c <= 6));
      check("t1_last", out_last, (c == 6));
      check("t1_done", done, (c == 7));
    end
    wait_idle("t1");

    // stalled stream with a fixed ready pattern
    ready_mode = 1;
    start_burst(0, 8);
    wait_idle("toggle");

    // address wrap at DEPTH-1
    ready_mode = 0;
    start_burst(DEPTH - 2, 4);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("wrap_rd_en", ram_read_en, 1);
      check("wrap_rd_addr", ram_read_addr, (DEPTH - 2 + c - 1) % DEPTH);
    end
    wait_idle("wrap");

    // zero-length burst
    start_burst(5, 0);
    @(negedge clk);
    check("zero_done", {done, busy, ram_read_en, out_valid}, 4'b1000);
    @(negedge clk);
    check("zero_after", {done, busy}, 2'b00);
    wait_idle("zero");

    // abort mid-burst, then a fresh burst
    ready_mode = 3;
    start_burst(40, 10);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    exp_done--;
    @(negedge clk);
    check("abort_busy", {busy, out_valid}, 2'b11);
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_after", {out_valid, busy, done}, 3'b000);
    ready_mode = 0;
    start_burst(100, 2);
    wait_idle("post_abort");

    // start while busy is ignored
    ready_mode = 2;
    start_burst(30, 6);
    @(posedge clk);
    #1;
    start       = 1'b1;
    start_addr  = AW'(50);
    start_count = CW'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("restart");

    // reset mid-burst
    start_burst(60, 20);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_done--;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_idle("mid_reset");

    // random bursts, including one longer than the RAM
    for (int i = 0; i < 12; i++) begin
      int a, n;
      ready_mode = $urandom_range(0, 2);
      a = $urandom_range(0, DEPTH - 1);
      n = (i == 5) ? 230 : $urandom_range(1, 48);
      start_burst(a, n);
      wait_idle("rand");
    end

    check("final_queue", exp_q.size(), 0);
    check("final_done", done_seen, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
